// File: rtl/xtea_pkg.sv
// Shared XTEA constants, FSM state type and key-word selection helpers
// used by the subkey generator and its round slice.
package xtea_pkg;

    localparam int          XTEA_WORD_W = 32;
    localparam int          XTEA_ROUNDS = 32;
    localparam int          XTEA_VEC_W  = XTEA_WORD_W * XTEA_ROUNDS;
    localparam logic [31:0] XTEA_DELTA  = 32'h9E3779B9;

    typedef enum logic [1:0] {
        KEX_IDLE = 2'd0,
        KEX_BUSY = 2'd1,
        KEX_DONE = 2'd2
    } kex_state_e;

    function automatic logic [1:0] key_idx_lo(input logic [31:0] sum);
        return 2'(sum);
    endfunction

    function automatic logic [1:0] key_idx_hi(input logic [31:0] sum);
        return 2'(sum >> 11);
    endfunction

    // k[0] sits in the most significant word of the 128-bit key
    function automatic logic [31:0] key_word(input logic [127:0] key, input logic [1:0] idx);
        return key[127 - 32*idx -: 32];
    endfunction

endpackage

// File: rtl/xtea_kex_round.sv
// One XTEA round of subkey material: A from the current sum, B from the
// advanced sum, and the advanced sum for the next round in the chain.
module xtea_kex_round
    import xtea_pkg::*;
#(
    parameter logic [31:0] P_DELTA = XTEA_DELTA
) (
    input  logic [31:0]  i_sum,
    input  logic [127:0] i_key,
    output logic [31:0]  o_a,
    output logic [31:0]  o_b,
    output logic [31:0]  o_sum_next
);

    always_comb begin
        o_sum_next = i_sum + P_DELTA;
        o_a        = i_sum + key_word(i_key, key_idx_lo(i_sum));
        o_b        = o_sum_next + key_word(i_key, key_idx_hi(o_sum_next));
    end

endmodule

// File: rtl/xtea_kex.sv
// XTEA round-subkey generator: expands a 128-bit key into two 32-word
// subkey vectors, ROUNDS_PER_CYC rounds per clock, then holds them valid.
module xtea_kex
    import xtea_pkg::*;
#(
    parameter logic [31:0] P_DELTA        = XTEA_DELTA,
    parameter int          ROUNDS_PER_CYC = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [127:0]          i_key,
    input  logic                  i_key_en,
    output logic [XTEA_VEC_W-1:0] o_keyex_a,
    output logic [XTEA_VEC_W-1:0] o_keyex_b,
    output logic                  o_key_ok,
    output logic                  o_busy
);

    localparam int         R        = ROUNDS_PER_CYC;
    localparam int         SW       = XTEA_WORD_W * R;
    localparam logic [5:0] CNT_STEP = 6'(R);
    localparam logic [5:0] CNT_LAST = 6'(XTEA_ROUNDS);

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_cfg
        $error("xtea_kex: ROUNDS_PER_CYC must be 1, 2 or 4");
    end

    kex_state_e       state_r, state_nxt;
    logic [127:0]     key_r;
    logic [31:0]      sum_r;
    logic [5:0]       cnt_r;
    logic [R:0][31:0] sum_chain;
    logic [SW-1:0]    new_a, new_b;
    logic             last_step;

    assign sum_chain[0] = sum_r;

    // Round slices chained on the running sum; oldest round lands most significant
    for (genvar g = 0; g < R; g++) begin : g_round
        xtea_kex_round #(.P_DELTA(P_DELTA)) u_round (
            .i_sum      (sum_chain[g]),
            .i_key      (key_r),
            .o_a        (new_a[SW-1-32*g -: 32]),
            .o_b        (new_b[SW-1-32*g -: 32]),
            .o_sum_next (sum_chain[g+1])
        );
    end

    assign last_step = (state_r == KEX_BUSY) && ((cnt_r + CNT_STEP) == CNT_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= KEX_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        if (i_key_en) begin
            state_nxt = KEX_BUSY;
        end else if (last_step) begin
            state_nxt = KEX_DONE;
        end
    end

    always_comb begin
        o_busy   = 1'b0;
        o_key_ok = 1'b0;
        case (state_r)
            KEX_BUSY: o_busy   = 1'b1;
            KEX_DONE: o_key_ok = 1'b1;
            default:  ;
        endcase
    end

    // A strobe always wins, so a reload during BUSY restarts from round 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            key_r     <= '0;
            sum_r     <= '0;
            cnt_r     <= '0;
            o_keyex_a <= '0;
            o_keyex_b <= '0;
        end else if (i_key_en) begin
            key_r <= i_key;
            sum_r <= '0;
            cnt_r <= '0;
        end else if (state_r == KEX_BUSY) begin
            sum_r     <= sum_chain[R];
            cnt_r     <= cnt_r + CNT_STEP;
            o_keyex_a <= {o_keyex_a[XTEA_VEC_W-1-SW:0], new_a};
            o_keyex_b <= {o_keyex_b[XTEA_VEC_W-1-SW:0], new_b};
        end
    end

endmodule

// File: tb/tb_xtea_kex.sv
// Bench for xtea_kex: one- and four-rounds-per-clock instances driven in
// parallel and checked against an arithmetic model of the subkey schedule.
module tb_xtea_kex;

    localparam logic [31:0] DELTA = 32'h9E3779B9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [127:0]  key = '0;
    logic          key_en = 1'b0;
    logic [1023:0] a1, b1, a4, b4;
    logic          ok1, busy1, ok4, busy4;

    int total = 0;
    int bad = 0;

    logic [31:0] ref_a [32];
    logic [31:0] ref_b [32];

    always #5 clk = ~clk;

    xtea_kex #(.ROUNDS_PER_CYC(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_key_en(key_en),
        .o_keyex_a(a1), .o_keyex_b(b1), .o_key_ok(ok1), .o_busy(busy1)
    );

    xtea_kex #(.ROUNDS_PER_CYC(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_key(key), .i_key_en(key_en),
        .o_keyex_a(a4), .o_keyex_b(b4), .o_key_ok(ok4), .o_busy(busy4)
    );

    function automatic logic [31:0] kw(input logic [127:0] k, input int idx);
        logic [127:0] t;
        t = k >> (96 - 32*idx);
        return t[31:0];
    endfunction

    function automatic logic [31:0] word_of(input logic [1023:0] v, input int i);
        return v[1023-32*i -: 32];
    endfunction

    // Subkeys straight from the definition: sum_i = i*delta, key word picked by sum bits
    task automatic model(input logic [127:0] k);
        logic [31:0] s0, s1;
        for (int i = 0; i < 32; i++) begin
            s0 = 32'(i) * DELTA;
            s1 = 32'(i + 1) * DELTA;
            ref_a[i] = s0 + kw(k, int'(s0 % 4));
            ref_b[i] = s1 + kw(k, int'((s1 / 2048) % 4));
        end
    endtask

    task automatic strobe(input logic [127:0] k);
        @(negedge clk);
        key = k;
        key_en = 1'b1;
        @(negedge clk);
        key_en = 1'b0;
    endtask

    // Cycles from the strobe edge until each instance raises key_ok; -1 if never
    task automatic wait_done(output int lat1, output int lat4);
        lat1 = -1;
        lat4 = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk);
            #1;
            if (ok4 && lat4 < 0) lat4 = c;
            if (ok1 && lat1 < 0) lat1 = c;
            if (lat1 >= 0 && lat4 >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ok1, busy1, ok4, busy4} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000", {ok1, busy1, ok4, busy4});
        end
        total++;
        if ((a1 | b1 | a4 | b4) !== '0) begin
            bad++;
            $display("FAIL reset_vectors: got nonzero want 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_key();
        int l1, l4;
        strobe('0);
        wait_done(l1, l4);
        total++;
        if (l1 !== 32) begin bad++; $display("FAIL zero_latency1: got %0d want 32", l1); end
        total++;
        if (l4 !== 8) begin bad++; $display("FAIL zero_latency4: got %0d want 8", l4); end
        wait_done(l1, l4);
        total++;
        if (word_of(a1, 0) !== 32'h0) begin bad++; $display("FAIL zero_A0: got %h want 00000000", word_of(a1, 0)); end
        total++;
        if (word_of(b1, 0) !== 32'h9E3779B9) begin bad++; $display("FAIL zero_B0: got %h want 9e3779b9", word_of(b1, 0)); end
        total++;
        if (word_of(a1, 1) !== 32'h9E3779B9) begin bad++; $display("FAIL zero_A1: got %h want 9e3779b9", word_of(a1, 1)); end
        total++;
        if (word_of(b1, 1) !== 32'h3C6EF372) begin bad++; $display("FAIL zero_B1: got %h want 3c6ef372", word_of(b1, 1)); end
        total++;
        if (word_of(b1, 31) !== 32'hC6EF3720) begin bad++; $display("FAIL zero_B31: got %h want c6ef3720", word_of(b1, 31)); end
    endtask

    task automatic test_known_key();
        int l1, l4;
        logic [127:0] k;
        k = 128'h11111111_22222222_33333333_44444444;
        model(k);
        strobe(k);
        wait_done(l1, l4);
        total++;
        if (l1 !== 32 || l4 !== 8) begin bad++; $display("FAIL known_latency: got %0d/%0d want 32/8", l1, l4); end
        total++;
        if (word_of(a1, 0) !== 32'h11111111) begin bad++; $display("FAIL known_A0: got %h want 11111111", word_of(a1, 0)); end
        total++;
        if (word_of(b1, 0) !== 32'hE27BBDFD) begin bad++; $display("FAIL known_B0: got %h want e27bbdfd", word_of(b1, 0)); end
        total++;
        if (word_of(a1, 1) !== 32'hC0599BDB) begin bad++; $display("FAIL known_A1: got %h want c0599bdb", word_of(a1, 1)); end
        for (int i = 0; i < 32; i++) begin
            total++;
            if (word_of(a1, i) !== ref_a[i] || word_of(b1, i) !== ref_b[i]) begin
                bad++;
                $display("FAIL known_word%0d: got %h/%h want %h/%h", i, word_of(a1, i), word_of(b1, i), ref_a[i], ref_b[i]);
            end
        end
    endtask

    task automatic test_hold_and_redone();
        logic [1023:0] sa, sb;
        sa = a1;
        sb = b1;
        @(negedge clk);
        key = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (ok1 !== 1'b1 || ok4 !== 1'b1) begin bad++; $display("FAIL hold_ok: got %b/%b want 1/1", ok1, ok4); end
        total++;
        if (a1 !== sa || b1 !== sb) begin bad++; $display("FAIL hold_vectors: got changed want stable"); end
        strobe(128'h0);
        #1;
        total++;
        if (ok1 !== 1'b0 || busy1 !== 1'b1) begin bad++; $display("FAIL redone_drop: got ok=%b busy=%b want ok=0 busy=1", ok1, busy1); end
    endtask

    task automatic test_reload();
        int l1, l4;
        logic [127:0] k1, k2;
        logic seen_ok;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        model(k2);
        strobe(k1);
        seen_ok = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk);
            #1;
            if (ok1) seen_ok = 1'b1;
        end
        strobe(k2);
        wait_done(l1, l4);
        total++;
        if (seen_ok !== 1'b0) begin bad++; $display("FAIL reload_ok_early: got 1 want 0"); end
        total++;
        if (l1 !== 32 || l4 !== 8) begin bad++; $display("FAIL reload_latency: got %0d/%0d want 32/8", l1, l4); end
        wait_done(l1, l4);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (word_of(a1, i) !== ref_a[i] || word_of(b1, i) !== ref_b[i]) begin
                bad++;
                $display("FAIL reload_word%0d: got %h/%h want %h/%h", i, word_of(a1, i), word_of(b1, i), ref_a[i], ref_b[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int l1, l4;
        logic [127:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        model(k);
        strobe(k);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ok1, busy1, ok4, busy4} !== 4'b0) begin bad++; $display("FAIL midrst_flags: got %b want 0000", {ok1, busy1, ok4, busy4}); end
        total++;
        if ((a1 | b1 | a4 | b4) !== '0) begin bad++; $display("FAIL midrst_vectors: got nonzero want 0"); end
        @(negedge clk);
        rst_n = 1'b1;
        strobe(k);
        wait_done(l1, l4);
        total++;
        if (l1 !== 32 || l4 !== 8) begin bad++; $display("FAIL midrst_latency: got %0d/%0d want 32/8", l1, l4); end
        wait_done(l1, l4);
        total++;
        if (word_of(a1, 31) !== ref_a[31] || word_of(b1, 17) !== ref_b[17] || a1 !== a4) begin
            bad++;
            $display("FAIL midrst_result: got %h/%h want %h/%h", word_of(a1, 31), word_of(b1, 17), ref_a[31], ref_b[17]);
        end
    endtask

    task automatic test_random_keys();
        int l1, l4;
        logic [127:0] k;
        int errs;
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            model(k);
            strobe(k);
            wait_done(l1, l4);
            wait_done(l1, l4);
            errs = 0;
            for (int i = 0; i < 32; i++) begin
                if (word_of(a1, i) !== ref_a[i] || word_of(b1, i) !== ref_b[i]) errs++;
            end
            total++;
            if (errs != 0) begin bad++; $display("FAIL rand%0d_model: got %0d wrong words want 0 key=%h", n, errs, k); end
            total++;
            if (a4 !== a1 || b4 !== b1 || ok4 !== 1'b1) begin bad++; $display("FAIL rand%0d_r4_equal: got differ want identical key=%h", n, k); end
        end
    endtask

    task automatic test_system();
        int l1, l4;
        logic [31:0] v0, v1;
        strobe('0);
        wait_done(l1, l4);
        wait_done(l1, l4);
        v0 = '0;
        v1 = '0;
        for (int i = 0; i < 32; i++) begin
            v0 = v0 + ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ word_of(a1, i));
            v1 = v1 + ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ word_of(b1, i));
        end
        total++;
        if ({v0, v1} !== 64'hDEE9D4D8F7131ED9) begin bad++; $display("FAIL sys_encrypt: got %h want dee9d4d8f7131ed9", {v0, v1}); end
        for (int i = 31; i >= 0; i--) begin
            v1 = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ word_of(b4, i));
            v0 = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ word_of(a4, i));
        end
        total++;
        if ({v0, v1} !== 64'h0) begin bad++; $display("FAIL sys_decrypt: got %h want 0000000000000000", {v0, v1}); end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_known_key();
        test_hold_and_redone();
        test_reload();
        test_reset_mid();
        test_random_keys();
        test_system();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
